// File: rtl/apb_bldc_ctrl_if.sv
// apb_bldc_ctrl_if: APB bus bundle between the host and the BLDC controller
interface apb_bldc_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pready;
   logic                    pslverr;
   modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
   modport slave (input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_bldc_ctrl.sv
// apb_bldc_ctrl: APB-programmed BLDC gate-drive controller with PWM, hall edge counting,
// stall/fault protection and a masked level interrupt.
module apb_bldc_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int PWM_WIDTH   = 12,
   parameter int STALL_WIDTH = 24
) (
   input  logic           pclk,
   input  logic           preset_n,
   apb_bldc_ctrl_if.slave apb,
   input  logic [2:0]     hall_in,
   input  logic [5:0]     comm_pattern,
   output logic [5:0]     phase_enable,
   output logic           irq
);
   logic [4:0]             ctrl;
   logic [PWM_WIDTH-1:0]   duty, period, duty_act, period_act, pwm_cnt;
   logic [STALL_WIDTH-1:0] stall_lim, stall_tmr;
   logic [DATA_WIDTH-1:0]  edge_cnt, rdata;
   logic [2:0]             h1, h2, h3, irq_stat, irq_set, irq_clr, idx, conflict;
   logic [5:0]             drive;
   logic                   en, en_clr, access, err, wr, hall_edge, bad, stall, fault, stall_ev, fault_ev, pwm;
   logic                   unused;
   assign unused    = ^{apb.pstrb, apb.pwdata};
   assign en        = ctrl[0];
   assign access    = apb.psel & apb.penable & ~apb.pready;
   assign idx       = apb.paddr[4:2];
   assign err       = apb.paddr[1:0] != 2'b00 || apb.paddr > ADDR_WIDTH'(8'h18)
                      || (apb.pwrite && (idx == 3'd4 || idx == 3'd6));
   assign wr        = access & apb.pwrite & ~err;
   assign en_clr    = !en || (wr && idx == 3'd0 && !apb.pwdata[0]);
   assign irq_clr   = (wr && idx == 3'd5) ? apb.pwdata[2:0] : 3'b000;
   assign hall_edge = h2 != h3;
   // both the current and the previous synchronised sample must be illegal
   assign bad       = (&h2 | ~|h2) & (&h3 | ~|h3);
   assign stall_ev  = en & ~stall & stall_lim != '0 & stall_tmr == stall_lim;
   assign fault_ev  = en & ~fault & bad;
   assign irq_set   = {hall_edge & en, fault_ev, stall_ev};
   assign pwm       = pwm_cnt < duty_act;
   assign conflict  = comm_pattern[5:3] & comm_pattern[2:0];
   assign drive     = (!en || stall || fault) ? 6'b000000 : ctrl[1] ? 6'b000111
                    : {comm_pattern[5:3] & {3{pwm}} & ~conflict, comm_pattern[2:0] & ~conflict};
   always_comb begin
      rdata = '0;
      case (idx)
         3'd0:    rdata = DATA_WIDTH'(ctrl);
         3'd1:    rdata = DATA_WIDTH'(duty);
         3'd2:    rdata = DATA_WIDTH'(period);
         3'd3:    rdata = DATA_WIDTH'(stall_lim);
         3'd4:    rdata = DATA_WIDTH'({pwm_cnt, pwm, fault, stall, h2});
         3'd5:    rdata = DATA_WIDTH'(irq_stat);
         3'd6:    rdata = edge_cnt;
         default: rdata = '0;
      endcase
   end
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         apb.pready   <= 1'b0;
         apb.pslverr  <= 1'b0;
         apb.prdata   <= '0;
         ctrl         <= '0;
         duty         <= '0;
         period       <= '1;
         duty_act     <= '0;
         period_act   <= '1;
         pwm_cnt      <= '0;
         stall_lim    <= '0;
         stall_tmr    <= '0;
         edge_cnt     <= '0;
         h1           <= '0;
         h2           <= '0;
         h3           <= '0;
         irq_stat     <= '0;
         stall        <= 1'b0;
         fault        <= 1'b0;
         irq          <= 1'b0;
         phase_enable <= '0;
      end else begin
         apb.pready  <= access;
         apb.pslverr <= access & err;
         apb.prdata  <= (access & ~apb.pwrite & ~err) ? rdata : '0;
         if (wr && idx == 3'd0) ctrl <= apb.pwdata[4:0];
         if (wr && idx == 3'd1) duty <= apb.pwdata[PWM_WIDTH-1:0];
         if (wr && idx == 3'd2) period <= apb.pwdata[PWM_WIDTH-1:0];
         if (wr && idx == 3'd3) stall_lim <= apb.pwdata[STALL_WIDTH-1:0];
         h1 <= hall_in;
         h2 <= h1;
         h3 <= h2;
         // shadows move into the active set only at wrap, keeping each period intact
         if (pwm_cnt >= period_act) begin
            pwm_cnt    <= '0;
            duty_act   <= duty;
            period_act <= period;
         end else
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
         stall_tmr    <= (en_clr || hall_edge) ? '0
                       : (stall_lim != '0 && stall_tmr == stall_lim) ? stall_tmr : stall_tmr + STALL_WIDTH'(1);
         edge_cnt     <= en_clr ? '0 : edge_cnt + DATA_WIDTH'(hall_edge);
         stall        <= en_clr ? 1'b0 : stall | stall_ev;
         fault        <= en_clr ? 1'b0 : fault | fault_ev;
         irq_stat     <= (irq_stat & ~irq_clr) | irq_set;
         irq          <= |(irq_stat & ctrl[4:2]);
         phase_enable <= drive;
      end
   end
endmodule

// File: tb/tb_apb_bldc_ctrl.sv
// tb_apb_bldc_ctrl: directed bench for apb_bldc_ctrl with hand-computed expectations
module tb_apb_bldc_ctrl;
   logic       pclk = 1'b0;
   logic       preset_n = 1'b0;
   logic [2:0] hall_in = 3'b101;
   logic [5:0] comm_pattern = 6'b100010;
   logic [5:0] phase_enable;
   logic       irq;
   int         n_vec = 0;
   int         n_err = 0;
   logic [2:0] seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

   apb_bldc_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

   apb_bldc_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .PWM_WIDTH(12), .STALL_WIDTH(24)) dut (
      .pclk(pclk), .preset_n(preset_n), .apb(bus), .hall_in(hall_in),
      .comm_pattern(comm_pattern), .phase_enable(phase_enable), .irq(irq));

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
      @(negedge pclk);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
      @(negedge pclk);
      bus.penable = 1'b1;
      for (int i = 0; i < 8 && !bus.pready; i++) @(negedge pclk);
      chk("pready", 32'(bus.pready), 32'd1);
      rd = bus.prdata;
      er = bus.pslverr;
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d);
      logic [31:0] rd;
      logic        er;
      xfer(1'b1, a, d, rd, er);
      chk(tag, 32'(er), 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] mask, input logic [31:0] exp);
      logic [31:0] rd;
      logic        er;
      xfer(1'b0, a, 32'd0, rd, er);
      chk({tag, " err"}, 32'(er), 32'd0);
      chk(tag, rd & mask, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          t, hi, lo, bad;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0; bus.pstrb = 4'hF;
      #22;
      chk("rst pready", 32'(bus.pready), 32'd0);
      chk("rst pslverr", 32'(bus.pslverr), 32'd0);
      chk("rst prdata", bus.prdata, 32'd0);
      chk("rst irq", 32'(irq), 32'd0);
      chk("rst phase", 32'(phase_enable), 32'd0);
      @(negedge pclk);
      preset_n = 1'b1;
      rd_chk("ctrl reset", 8'h00, 32'hFFFF_FFFF, 32'h0);
      @(negedge pclk);
      chk("pready one cycle", 32'(bus.pready), 32'd0);
      chk("prdata idle", bus.prdata, 32'd0);
      rd_chk("period reset", 8'h08, 32'hFFFF_FFFF, 32'hFFF);
      rd_chk("duty reset", 8'h04, 32'hFFFF_FFFF, 32'h0);
      rd_chk("status reset", 8'h10, 32'h3F, 32'h05);
      rd_chk("edge_cnt reset", 8'h18, 32'hFFFF_FFFF, 32'h0);

      xfer(1'b0, 8'h1C, 32'd0, rd, er);
      chk("unmapped err", 32'(er), 32'd1);
      chk("unmapped prdata", rd, 32'd0);
      xfer(1'b0, 8'h06, 32'd0, rd, er);
      chk("unaligned err", 32'(er), 32'd1);
      xfer(1'b1, 8'h10, 32'hFFFF_FFFF, rd, er);
      chk("status write err", 32'(er), 32'd1);
      rd_chk("status unchanged", 8'h10, 32'h3F, 32'h05);
      xfer(1'b1, 8'h01, 32'h1F, rd, er);
      chk("unaligned write err", 32'(er), 32'd1);
      rd_chk("ctrl untouched", 8'h00, 32'hFFFF_FFFF, 32'h0);

      wr("wr duty", 8'h04, 32'h100);
      wr("wr period", 8'h08, 32'h3FF);
      rd_chk("duty readback", 8'h04, 32'hFFFF_FFFF, 32'h100);
      wr("wr ctrl en", 8'h00, 32'h1);
      t = 0;
      while (!phase_enable[5] && t < 5000) begin @(negedge pclk); t++; end
      chk("ah start", 32'(phase_enable[5]), 32'd1);
      hi = 0; bad = 0;
      while (phase_enable[5] && hi < 2000) begin
         if (phase_enable !== 6'b100010) bad++;
         hi++;
         @(negedge pclk);
      end
      lo = 0;
      while (!phase_enable[5] && lo < 2000) begin
         if (phase_enable !== 6'b000010) bad++;
         lo++;
         @(negedge pclk);
      end
      chk("ah high cycles", hi, 32'd256);
      chk("ah low cycles", lo, 32'd768);
      chk("pwm pattern", bad, 32'd0);

      wr("wr duty full", 8'h04, 32'h400);
      repeat (1100) @(negedge pclk);
      bad = 0;
      repeat (1030) begin if (phase_enable !== 6'b100010) bad++; @(negedge pclk); end
      chk("duty 100pct", bad, 32'd0);
      wr("wr duty zero", 8'h04, 32'h0);
      repeat (1100) @(negedge pclk);
      bad = 0;
      repeat (1030) begin if (phase_enable !== 6'b000010) bad++; @(negedge pclk); end
      chk("duty 0pct", bad, 32'd0);

      wr("brake on", 8'h00, 32'h3);
      repeat (2) @(negedge pclk);
      chk("brake phase", 32'(phase_enable), 32'h07);
      wr("brake off", 8'h00, 32'h1);
      comm_pattern = 6'b100100;
      repeat (2) @(negedge pclk);
      chk("conflict A", 32'(phase_enable), 32'h00);
      comm_pattern = 6'b001110;
      repeat (2) @(negedge pclk);
      chk("no conflict", 32'(phase_enable), 32'h06);
      comm_pattern = 6'b001111;
      repeat (2) @(negedge pclk);
      chk("conflict C", 32'(phase_enable), 32'h06);
      comm_pattern = 6'b100010;

      wr("ctrl off", 8'h00, 32'h0);
      wr("stall limit", 8'h0C, 32'd100);
      wr("ctrl stall irq", 8'h00, 32'h5);
      repeat (95) @(negedge pclk);
      chk("irq before stall", 32'(irq), 32'd0);
      chk("bl before stall", 32'(phase_enable[1]), 32'd1);
      repeat (10) @(negedge pclk);
      chk("irq stall", 32'(irq), 32'd1);
      chk("phase stall", 32'(phase_enable), 32'd0);
      rd_chk("status stall", 8'h10, 32'h1F, 32'h0D);
      wr("irq clr stall", 8'h14, 32'h1);
      repeat (2) @(negedge pclk);
      chk("irq cleared", 32'(irq), 32'd0);
      rd_chk("irq_stat cleared", 8'h14, 32'h7, 32'h0);

      wr("stall limit 0", 8'h0C, 32'd0);
      wr("ctrl off", 8'h00, 32'h0);
      rd_chk("stall cleared", 8'h10, 32'h1F, 32'h05);
      wr("ctrl fault irq", 8'h00, 32'h9);
      hall_in = 3'b111;
      repeat (3) @(negedge pclk);
      hall_in = 3'b101;
      repeat (4) @(negedge pclk);
      chk("irq fault", 32'(irq), 32'd1);
      chk("phase fault", 32'(phase_enable), 32'd0);
      rd_chk("status fault", 8'h10, 32'h1F, 32'h15);
      wr("ctrl off", 8'h00, 32'h0);
      wr("ctrl on", 8'h00, 32'h1);
      rd_chk("fault cleared", 8'h10, 32'h1F, 32'h05);
      chk("phase after fault", 32'(phase_enable), 32'h02);
      wr("irq clr all", 8'h14, 32'h7);
      rd_chk("irq_stat empty", 8'h14, 32'h7, 32'h0);

      wr("ctrl edge irq", 8'h00, 32'h11);
      for (int i = 0; i < 6; i++) begin
         hall_in = seq[i];
         repeat (5) @(negedge pclk);
      end
      rd_chk("edge_cnt six", 8'h18, 32'hFFFF_FFFF, 32'd6);
      chk("irq edge", 32'(irq), 32'd1);
      rd_chk("irq_stat edge", 8'h14, 32'h7, 32'h4);
      xfer(1'b1, 8'h18, 32'd5, rd, er);
      chk("edge_cnt write err", 32'(er), 32'd1);
      rd_chk("edge_cnt unchanged", 8'h18, 32'hFFFF_FFFF, 32'd6);

      repeat (37) @(negedge pclk);
      chk("bl before reset", 32'(phase_enable[1]), 32'd1);
      #2 preset_n = 1'b0;
      #1;
      chk("async rst phase", 32'(phase_enable), 32'd0);
      chk("async rst irq", 32'(irq), 32'd0);
      @(negedge pclk);
      preset_n = 1'b1;
      rd_chk("period after reset", 8'h08, 32'hFFFF_FFFF, 32'hFFF);
      rd_chk("ctrl after reset", 8'h00, 32'hFFFF_FFFF, 32'h0);
      rd_chk("edge_cnt after reset", 8'h18, 32'hFFFF_FFFF, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
